// File: rtl/crack_scheduler.sv
// crack_scheduler
//
// Shares the RC4 key search across NUM_CORES cracking cores. Fixed-size key
// chunks are handed to requesting cores in round-robin order. The first hit
// report latches the winning key and halts every core. If the key space runs
// out with no hit, the block reports not_found.
//
// Optional build macro: CRACK_SCHED_STATS_EN
//   When defined, two extra outputs exist:
//     chunks_issued - saturating grant counter
//     hit_core      - index of the winning core
//
// Ports
//   clock, reset   rising-edge clock; synchronous active-high reset
//   start          launch a search (honoured in IDLE, FOUND, NOT_FOUND)
//   core_req       per-core chunk request, held until granted
//   core_busy      per-core "working a chunk"
//   core_hit       per-core single-cycle hit pulse
//   core_key       packed per-core keys, 24 bits each, valid with core_hit
//   core_grant     one-hot, one-cycle grant pulse
//   chunk_base     first key of the granted chunk (valid with core_grant)
//   chunk_end      last key of the granted chunk, inclusive
//   halt           stop all cores
//   found          sticky: key cracked
//   not_found      sticky: key space exhausted
//   found_key      winning key, valid while found
//   display_key    next undispatched chunk base, saturated at MAX_KEY
//   busy           high while dispatching or draining
//   chunks_issued  (stats build only) number of grants issued
//   hit_core       (stats build only) index of the winning core
module crack_scheduler #(
  parameter int unsigned NUM_CORES  = 4,
  parameter logic [23:0] CHUNK_SIZE = 24'h01_00_00,
  parameter logic [23:0] MIN_KEY    = 24'h00_00_00,
  parameter logic [23:0] MAX_KEY    = 24'h3F_FF_FF
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [NUM_CORES-1:0]    core_req,
  input  logic [NUM_CORES-1:0]    core_busy,
  input  logic [NUM_CORES-1:0]    core_hit,
  input  logic [24*NUM_CORES-1:0] core_key,
  output logic [NUM_CORES-1:0]    core_grant,
  output logic [23:0]             chunk_base,
  output logic [23:0]             chunk_end,
  output logic                    halt,
  output logic                    found,
  output logic                    not_found,
  output logic [23:0]             found_key,
  output logic [23:0]             display_key,
  output logic                    busy
`ifdef CRACK_SCHED_STATS_EN
  ,
  output logic [15:0]             chunks_issued,
  output logic [2:0]              hit_core
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DISPATCH,
    S_DRAIN,
    S_FOUND,
    S_NOT_FOUND
  } state_t;

  // Clamp a 25-bit key position to the top of the search range.
  function automatic logic [23:0] sat_key(input logic [24:0] v);
    return (v > {1'b0, MAX_KEY}) ? MAX_KEY : v[23:0];
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t                 state_q, state_d;
  // One bit wider than a key so the chunk after the last one cannot wrap to 0.
  logic [24:0]            next_base_q, next_base_d;
  logic [2:0]             rr_ptr_q, rr_ptr_d;

  logic [NUM_CORES-1:0]   grant_d;
  logic [23:0]            chunk_base_d, chunk_end_d, found_key_d, display_d;
  logic                   halt_d, found_d, not_found_d, busy_d;

  logic [NUM_CORES-1:0]   req_eff;
  logic                   win_vld;
  logic [2:0]             win_idx;
  logic [NUM_CORES-1:0]   win_oh;
  logic                   hit_vld;
  logic [23:0]            hit_key;
  logic [24:0]            nb_inc;
  logic [3:0]             win_next;

`ifdef CRACK_SCHED_STATS_EN
  logic [15:0]            chunks_d;
  logic [2:0]             hit_idx;
  logic [2:0]             hit_core_d;
`endif

  // Round-robin arbiter and hit priority encoder
  always_comb begin
    // A core is still holding req during its own grant cycle; ignore it there.
    req_eff = core_req & ~core_grant;
    win_vld = 1'b0;
    win_idx = 3'd0;
    win_oh  = '0;
    // Second loop overrides the first, so cores at or after rr_ptr win over
    // the wrapped-around ones; descending order leaves the lowest index.
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (req_eff[i] && (i < int'(rr_ptr_q))) begin
        win_vld   = 1'b1;
        win_idx   = 3'(i);
        win_oh    = '0;
        win_oh[i] = 1'b1;
      end
    end
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (req_eff[i] && (i >= int'(rr_ptr_q))) begin
        win_vld   = 1'b1;
        win_idx   = 3'(i);
        win_oh    = '0;
        win_oh[i] = 1'b1;
      end
    end

    hit_vld = 1'b0;
    hit_key = 24'd0;
`ifdef CRACK_SCHED_STATS_EN
    hit_idx = 3'd0;
`endif
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (core_hit[i]) begin
        hit_vld = 1'b1;
        hit_key = core_key[24*i +: 24];
`ifdef CRACK_SCHED_STATS_EN
        hit_idx = 3'(i);
`endif
      end
    end

    nb_inc   = next_base_q + {1'b0, CHUNK_SIZE};
    win_next = {1'b0, win_idx} + 4'd1;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    next_base_d  = next_base_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = '0;
    chunk_base_d = chunk_base;
    chunk_end_d  = chunk_end;
    halt_d       = halt;
    found_d      = found;
    not_found_d  = not_found;
    found_key_d  = found_key;
    display_d    = display_key;
`ifdef CRACK_SCHED_STATS_EN
    chunks_d     = chunks_issued;
    hit_core_d   = hit_core;
`endif

    case (state_q)
      S_IDLE, S_FOUND, S_NOT_FOUND: begin
        if (start) begin
          state_d     = S_DISPATCH;
          next_base_d = {1'b0, MIN_KEY};
          display_d   = MIN_KEY;
          halt_d      = 1'b0;
          found_d     = 1'b0;
          not_found_d = 1'b0;
`ifdef CRACK_SCHED_STATS_EN
          chunks_d    = 16'd0;
`endif
        end
      end

      S_DISPATCH, S_DRAIN: begin
        if (hit_vld) begin
          // A hit wins over any grant in the same cycle.
          state_d     = S_FOUND;
          found_d     = 1'b1;
          halt_d      = 1'b1;
          found_key_d = hit_key;
`ifdef CRACK_SCHED_STATS_EN
          hit_core_d  = hit_idx;
`endif
        end else if (state_q == S_DISPATCH) begin
          if (win_vld) begin
            grant_d      = win_oh;
            chunk_base_d = next_base_q[23:0];
            chunk_end_d  = sat_key(next_base_q + {1'b0, CHUNK_SIZE} - 25'd1);
            next_base_d  = nb_inc;
            display_d    = sat_key(nb_inc);
            rr_ptr_d     = (win_next == 4'(NUM_CORES)) ? 3'd0 : win_next[2:0];
`ifdef CRACK_SCHED_STATS_EN
            chunks_d     = sat_inc16(chunks_issued);
`endif
            if (nb_inc > {1'b0, MAX_KEY}) begin
              state_d = S_DRAIN;
            end
          end
        end else begin
          // A grant still on the wire means that core has not raised busy yet.
          if ((core_busy == '0) && (core_grant == '0)) begin
            state_d     = S_NOT_FOUND;
            not_found_d = 1'b1;
            halt_d      = 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_DISPATCH) || (state_d == S_DRAIN);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      next_base_q <= {1'b0, MIN_KEY};
      rr_ptr_q    <= 3'd0;
      core_grant  <= '0;
      chunk_base  <= 24'd0;
      chunk_end   <= 24'd0;
      halt        <= 1'b0;
      found       <= 1'b0;
      not_found   <= 1'b0;
      found_key   <= 24'd0;
      display_key <= MIN_KEY;
      busy        <= 1'b0;
`ifdef CRACK_SCHED_STATS_EN
      chunks_issued <= 16'd0;
      hit_core      <= 3'd0;
`endif
    end else begin
      state_q     <= state_d;
      next_base_q <= next_base_d;
      rr_ptr_q    <= rr_ptr_d;
      core_grant  <= grant_d;
      chunk_base  <= chunk_base_d;
      chunk_end   <= chunk_end_d;
      halt        <= halt_d;
      found       <= found_d;
      not_found   <= not_found_d;
      found_key   <= found_key_d;
      display_key <= display_d;
      busy        <= busy_d;
`ifdef CRACK_SCHED_STATS_EN
      chunks_issued <= chunks_d;
      hit_core      <= hit_core_d;
`endif
    end
  end

endmodule

// File: tb/tb_crack_scheduler.sv
// Directed bench for crack_scheduler. Three instances:
//   dut   - default parameters (4 cores, 64K chunks)
//   dut_s - 2 cores, 256-key chunks, MAX_KEY 3FF
//   dut_m - 2 cores, 256-key chunks, MAX_KEY 27F
// dut_s and dut_m share their core inputs.
module tb_crack_scheduler;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  always #5 clock = ~clock;

  logic [3:0]  core_req  = '0, core_busy = '0, core_hit = '0;
  logic [95:0] core_key  = '0;
  logic [3:0]  core_grant;
  logic [23:0] chunk_base, chunk_end, found_key, display_key;
  logic        halt, found, not_found, busy;

  logic [1:0]  s_req = '0, s_busy = '0, s_hit = '0;
  logic [47:0] s_key = '0;
  logic [1:0]  s_grant, m_grant;
  logic [23:0] s_base, s_end, s_fkey, s_disp, m_base, m_end, m_fkey, m_disp;
  logic        s_halt, s_found, s_nf, s_busy_o, m_halt, m_found, m_nf, m_busy_o;

`ifdef CRACK_SCHED_STATS_EN
  logic [15:0] chunks_issued, s_chunks, m_chunks;
  logic [2:0]  hit_core, s_hit_core, m_hit_core;
`endif

  int checks = 0;
  int failures = 0;

  crack_scheduler dut (
    .clock(clock), .reset(reset), .start(start),
    .core_req(core_req), .core_busy(core_busy), .core_hit(core_hit), .core_key(core_key),
    .core_grant(core_grant), .chunk_base(chunk_base), .chunk_end(chunk_end),
    .halt(halt), .found(found), .not_found(not_found), .found_key(found_key),
    .display_key(display_key), .busy(busy)
`ifdef CRACK_SCHED_STATS_EN
    , .chunks_issued(chunks_issued), .hit_core(hit_core)
`endif
  );

  crack_scheduler #(.NUM_CORES(2), .CHUNK_SIZE(24'h100), .MIN_KEY(24'h0), .MAX_KEY(24'h3FF)) dut_s (
    .clock(clock), .reset(reset), .start(start),
    .core_req(s_req), .core_busy(s_busy), .core_hit(s_hit), .core_key(s_key),
    .core_grant(s_grant), .chunk_base(s_base), .chunk_end(s_end),
    .halt(s_halt), .found(s_found), .not_found(s_nf), .found_key(s_fkey),
    .display_key(s_disp), .busy(s_busy_o)
`ifdef CRACK_SCHED_STATS_EN
    , .chunks_issued(s_chunks), .hit_core(s_hit_core)
`endif
  );

  crack_scheduler #(.NUM_CORES(2), .CHUNK_SIZE(24'h100), .MIN_KEY(24'h0), .MAX_KEY(24'h27F)) dut_m (
    .clock(clock), .reset(reset), .start(start),
    .core_req(s_req), .core_busy(s_busy), .core_hit(s_hit), .core_key(s_key),
    .core_grant(m_grant), .chunk_base(m_base), .chunk_end(m_end),
    .halt(m_halt), .found(m_found), .not_found(m_nf), .found_key(m_fkey),
    .display_key(m_disp), .busy(m_busy_o)
`ifdef CRACK_SCHED_STATS_EN
    , .chunks_issued(m_chunks), .hit_core(m_hit_core)
`endif
  );

  // Advance one clock; outputs are examined 1ns after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0;
    core_req = '0; core_busy = '0; core_hit = '0; core_key = '0;
    s_req = '0; s_busy = '0; s_hit = '0; s_key = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic launch();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (core_grant !== 4'h0) begin failures++; $display("FAIL reset_grant got=%h exp=%h", core_grant, 4'h0); end
    checks++; if (chunk_base !== 24'h0) begin failures++; $display("FAIL reset_base got=%h exp=%h", chunk_base, 24'h0); end
    checks++; if (chunk_end !== 24'h0) begin failures++; $display("FAIL reset_end got=%h exp=%h", chunk_end, 24'h0); end
    checks++; if ({halt, found, not_found, busy} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=%b", {halt, found, not_found, busy}, 4'b0000); end
    checks++; if (found_key !== 24'h0) begin failures++; $display("FAIL reset_fkey got=%h exp=%h", found_key, 24'h0); end
    checks++; if (display_key !== 24'h0) begin failures++; $display("FAIL reset_disp got=%h exp=%h", display_key, 24'h0); end
  endtask

  task automatic test_single_core();
    logic [23:0] eb;
    do_reset();
    launch();
    checks++; if (s_busy_o !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", s_busy_o); end
    checks++; if (s_grant !== 2'b00) begin failures++; $display("FAIL single_nogrant got=%b exp=00", s_grant); end
    s_req = 2'b01;
    for (int c = 0; c < 4; c++) begin
      for (int w = 0; w < 6; w++) begin
        tick();
        if (s_grant != 2'b00) break;
      end
      eb = 24'(c * 256);
      checks++; if (s_grant !== 2'b01) begin failures++; $display("FAIL single_grant%0d got=%b exp=01", c, s_grant); end
      checks++; if (s_base !== eb) begin failures++; $display("FAIL single_base%0d got=%h exp=%h", c, s_base, eb); end
      checks++; if (s_end !== eb + 24'hFF) begin failures++; $display("FAIL single_end%0d got=%h exp=%h", c, s_end, eb + 24'hFF); end
      s_req = 2'b00; s_busy = 2'b01;
      tick();
      s_busy = 2'b00;
      if (c < 3) s_req = 2'b01;
    end
    checks++; if (s_disp !== 24'h3FF) begin failures++; $display("FAIL single_disp got=%h exp=%h", s_disp, 24'h3FF); end
    checks++; if ({s_nf, s_busy_o} !== 2'b01) begin failures++; $display("FAIL single_drain got=%b exp=01", {s_nf, s_busy_o}); end
    tick();
    checks++; if ({s_nf, s_halt, s_busy_o, s_found} !== 4'b1100) begin failures++; $display("FAIL single_notfound got=%b exp=1100", {s_nf, s_halt, s_busy_o, s_found}); end
  endtask

  task automatic test_max_clip();
    do_reset();
    launch();
    s_req = 2'b01;
    tick();
    checks++; if (m_grant !== 2'b01 || m_base !== 24'h0) begin failures++; $display("FAIL clip_g0 got=%b/%h exp=01/000000", m_grant, m_base); end
    tick();
    checks++; if (m_grant !== 2'b00) begin failures++; $display("FAIL clip_mask got=%b exp=00", m_grant); end
    tick();
    tick();
    tick();
    checks++; if (m_grant !== 2'b01) begin failures++; $display("FAIL clip_g2 got=%b exp=01", m_grant); end
    checks++; if (m_base !== 24'h200) begin failures++; $display("FAIL clip_base got=%h exp=%h", m_base, 24'h200); end
    checks++; if (m_end !== 24'h27F) begin failures++; $display("FAIL clip_end got=%h exp=%h", m_end, 24'h27F); end
    checks++; if (m_disp !== 24'h27F) begin failures++; $display("FAIL clip_disp got=%h exp=%h", m_disp, 24'h27F); end
    s_req = 2'b00;
  endtask

  task automatic test_round_robin();
    logic [3:0]  eg;
    logic [23:0] eb;
    do_reset();
    launch();
    core_req = 4'hF;
    for (int k = 0; k < 8; k++) begin
      if (k == 2) start = 1'b1;
      tick();
      start = 1'b0;
      eg = 4'(1 << (k % 4));
      eb = 24'(k * 32'h10000);
      checks++; if (core_grant !== eg) begin failures++; $display("FAIL rr_grant%0d got=%b exp=%b", k, core_grant, eg); end
      checks++; if (chunk_base !== eb) begin failures++; $display("FAIL rr_base%0d got=%h exp=%h", k, chunk_base, eb); end
      checks++; if (chunk_end !== eb + 24'hFFFF) begin failures++; $display("FAIL rr_end%0d got=%h exp=%h", k, chunk_end, eb + 24'hFFFF); end
      checks++; if (display_key !== eb + 24'h10000) begin failures++; $display("FAIL rr_disp%0d got=%h exp=%h", k, display_key, eb + 24'h10000); end
    end
  endtask

  task automatic test_hit_priority();
    do_reset();
    launch();
    core_req = 4'b0001;
    core_hit = 4'b0100;
    core_key[71:48] = 24'h12_34_56;
    tick();
    core_hit = 4'b0000;
    checks++; if (core_grant !== 4'h0) begin failures++; $display("FAIL hit_nogrant got=%b exp=0000", core_grant); end
    checks++; if ({found, halt, busy, not_found} !== 4'b1100) begin failures++; $display("FAIL hit_flags got=%b exp=1100", {found, halt, busy, not_found}); end
    checks++; if (found_key !== 24'h12_34_56) begin failures++; $display("FAIL hit_key got=%h exp=%h", found_key, 24'h123456); end
    core_hit = 4'b0010;
    core_key[47:24] = 24'h99_99_99;
    tick();
    core_hit = 4'b0000;
    checks++; if (found_key !== 24'h12_34_56 || found !== 1'b1) begin failures++; $display("FAIL hit_sticky got=%h exp=%h", found_key, 24'h123456); end
    checks++; if (core_grant !== 4'h0) begin failures++; $display("FAIL hit_found_nogrant got=%b exp=0000", core_grant); end
  endtask

  task automatic test_multi_hit();
    do_reset();
    launch();
    core_key[47:24] = 24'h00_00_AA;
    core_key[95:72] = 24'h00_00_BB;
    core_hit = 4'b1010;
    tick();
    core_hit = 4'b0000;
    checks++; if (found_key !== 24'h00_00_AA) begin failures++; $display("FAIL multi_key got=%h exp=%h", found_key, 24'hAA); end
    launch();
    checks++; if ({found, halt, busy} !== 3'b001) begin failures++; $display("FAIL relaunch_flags got=%b exp=001", {found, halt, busy}); end
    checks++; if (display_key !== 24'h0) begin failures++; $display("FAIL relaunch_disp got=%h exp=%h", display_key, 24'h0); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    launch();
    core_req = 4'hF;
    tick();
    checks++; if (core_grant !== 4'b0001) begin failures++; $display("FAIL rst_pre_grant got=%b exp=0001", core_grant); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (core_grant !== 4'h0) begin failures++; $display("FAIL rst_grant got=%b exp=0000", core_grant); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (display_key !== 24'h0) begin failures++; $display("FAIL rst_disp got=%h exp=%h", display_key, 24'h0); end
    core_req = 4'h0;
    launch();
    core_req = 4'hF;
    tick();
    checks++; if (core_grant !== 4'b0001 || chunk_base !== 24'h0) begin failures++; $display("FAIL rst_relaunch got=%b/%h exp=0001/000000", core_grant, chunk_base); end
    checks++; if (display_key !== 24'h01_00_00) begin failures++; $display("FAIL rst_relaunch_disp got=%h exp=%h", display_key, 24'h010000); end
    core_req = 4'h0;
  endtask

  initial begin
    test_reset();
    test_single_core();
    test_max_clip();
    test_round_robin();
    test_hit_priority();
    test_multi_hit();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
